fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 161 ++++++++++++++++
 tb/tb_fetch_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Instruction fetch front end with a program-memory loader port.
//   IDLE  : nothing fetched; waits for run (priority) or a loader request.
//   FETCH : reads program memory at pc and presents the word to decode through
//           a single valid/ready output register. A word whose opcode nibble is
//           4'b0000 is a JMP: it is consumed here and never presented. An
//           execute-stage redirect (br_valid) flushes the output register.
//   LOAD  : the loader writes one word per cycle into program memory.
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active low
//   run                 1 = fetch enabled, 0 = stop fetching / allow loading
//   mem_addr[7:0]       program memory address (pc, or ld_addr while loading)
//   mem_rdata[15:0]     combinational read data for mem_addr
//   mem_wdata[15:0]     program memory write data (0 outside LOAD)
//   mem_we              program memory write strobe
//   ld_req/ld_addr/ld_data   loader write request, address and data
//   ld_gnt              loader word accepted this cycle
//   br_valid/br_target  redirect request and target
//   instr_valid/instr/instr_pc  registered instruction to decode and its address
//   instr_ready         decode accepts instr when instr_valid & instr_ready
// -----------------------------------------------------------------------------
module fetch_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic        ld_req,
    input  logic [7:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_gnt,
    input  logic        br_valid,
    input  logic [7:0]  br_target,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [7:0]  instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  ipc_q, ipc_d;
    logic        vld_q, vld_d;

    // The output register may take a new word when it is empty or when decode
    // is consuming the current one this cycle.
    logic load_opp;
    logic is_jmp;

    assign load_opp = !vld_q || instr_ready;
    assign is_jmp   = (mem_rdata[15:12] == 4'b0000);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= 8'd0;
            instr_q <= 16'd0;
            ipc_q   <= 8'd0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        vld_d   = vld_q;

        case (state_q)
            S_IDLE: begin
                vld_d = 1'b0;
                if (run) begin
                    state_d = S_FETCH;
                end else if (ld_req) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                // run is deliberately ignored: a load burst finishes first.
                vld_d = 1'b0;
                if (!ld_req) begin
                    state_d = S_IDLE;
                end
            end

            S_FETCH: begin
                if (!run) begin
                    // Stop: drop the pending word but keep pc; a coincident
                    // redirect still lands so restart resumes at the target.
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                    if (br_valid) begin
                        pc_d = br_target;
                    end
                end else if (br_valid) begin
                    // Redirect flushes even a stalled word.
                    pc_d  = br_target;
                    vld_d = 1'b0;
                end else if (load_opp) begin
                    if (is_jmp) begin
                        // JMP is resolved here and leaves a one-cycle bubble.
                        pc_d  = mem_rdata[7:0];
                        vld_d = 1'b0;
                    end else begin
                        instr_d = mem_rdata;
                        ipc_d   = pc_q;
                        vld_d   = 1'b1;
                        pc_d    = pc_q + 8'd1;   // wraps 255 -> 0
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    // Outputs: the loader only reaches memory while in LOAD.
    always_comb begin
        mem_addr  = pc_q;
        mem_wdata = 16'd0;
        mem_we    = 1'b0;
        ld_gnt    = 1'b0;
        if (state_q == S_LOAD) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
            mem_we    = ld_req;
            ld_gnt    = ld_req;
        end
    end

    assign instr_valid = vld_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        run;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        ld_req;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_gnt;
    logic        br_valid;
    logic [7:0]  br_target;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;

    fetch_controller dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_gnt      (ld_gnt),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: combinational read, write on the strobed edge.
    logic [15:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    int n_vec = 0;
    int n_err = 0;
    int gcnt  = 0;

    // Reference model: architectural view (mode, program counter, presented
    // word, memory contents), updated once per clock from the stated rules.
    localparam int M_IDLE = 0, M_FETCH = 1, M_LOAD = 2;
    int          m_mode;
    logic [7:0]  m_pc, m_ipc;
    logic [15:0] m_instr;
    bit          m_v;
    logic [15:0] mmem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pc = 8'd0; m_ipc = 8'd0; m_instr = 16'd0; m_v = 1'b0;
    endtask

    task automatic model_check();
        bit loading;
        loading = (m_mode == M_LOAD);
        chk("mem_addr",    32'(mem_addr),    loading ? 32'(ld_addr) : 32'(m_pc));
        chk("mem_we",      32'(mem_we),      32'(loading && ld_req));
        chk("ld_gnt",      32'(ld_gnt),      32'(loading && ld_req));
        chk("mem_wdata",   32'(mem_wdata),   loading ? 32'(ld_data) : 32'd0);
        chk("instr_valid", 32'(instr_valid), 32'(m_v));
        chk("instr_pc",    32'(instr_pc),    32'(m_ipc));
        chk("instr",       32'(instr),       32'(m_instr));
    endtask

    task automatic model_update();
        logic [15:0] w;
        case (m_mode)
            M_IDLE: begin
                m_v = 1'b0;
                if (run) m_mode = M_FETCH;
                else if (ld_req) m_mode = M_LOAD;
            end
            M_LOAD: begin
                if (ld_req) mmem[ld_addr] = ld_data;
                else m_mode = M_IDLE;
            end
            default: begin
                w = mmem[m_pc];
                if (!run) begin
                    m_mode = M_IDLE;
                    m_v = 1'b0;
                    if (br_valid) m_pc = br_target;
                end else if (br_valid) begin
                    m_pc = br_target;
                    m_v = 1'b0;
                end else if (!m_v || instr_ready) begin
                    if (w[15:12] == 4'h0) begin
                        m_pc = w[7:0];
                        m_v = 1'b0;
                    end else begin
                        m_instr = w;
                        m_ipc = m_pc;
                        m_v = 1'b1;
                        m_pc = 8'((int'(m_pc) + 1) % 256);
                    end
                end
            end
        endcase
    endtask

    // One clock: inputs are already set (at the falling edge); check after
    // settling, then advance the model on the rising edge.
    task automatic step(input bit dir, input bit ev, input int epc);
        #1;
        model_check();
        if (dir) begin
            chk("dir_valid", 32'(instr_valid), 32'(ev));
            if (ev) chk("dir_pc", 32'(instr_pc), 32'(epc));
        end
        if (ld_gnt) gcnt++;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic mid_reset();
        #1;
        model_check();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mem_we",    32'(mem_we),      32'd0);
        chk("rst_ld_gnt",    32'(ld_gnt),      32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata),   32'd0);
        chk("rst_valid",     32'(instr_valid), 32'd0);
        chk("rst_instr",     32'(instr),       32'd0);
        chk("rst_instr_pc",  32'(instr_pc),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),    32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] saved;

        rst = 1'b0; run = 1'b0; ld_req = 1'b0; ld_addr = 8'd0; ld_data = 16'd0;
        br_valid = 1'b0; br_target = 8'd0; instr_ready = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        model_check();
        @(negedge clk);
        rst = 1'b1;

        // Loader burst of three words, then back to IDLE
        gcnt = 0;
        ld_req = 1'b1; ld_addr = 8'd0; ld_data = 16'h60FF;
        step(1'b0, 1'b0, 0);                       // IDLE -> LOAD, no grant yet
        ld_addr = 8'd0; ld_data = 16'h60FF; step(1'b0, 1'b0, 0);
        ld_addr = 8'd1; ld_data = 16'h61FE; step(1'b0, 1'b0, 0);
        ld_addr = 8'd2; ld_data = 16'h62FD; step(1'b0, 1'b0, 0);
        ld_req = 1'b0; step(1'b0, 1'b0, 0);         // LOAD -> IDLE
        chk("ld_gnt_cycles", 32'(gcnt), 32'd3);
        chk("mem0", 32'(mem[0]), 32'h60FF);
        chk("mem1", 32'(mem[1]), 32'h61FE);
        chk("mem2", 32'(mem[2]), 32'h62FD);
        step(1'b0, 1'b0, 0);                        // stays IDLE

        // Fill the rest of memory through the loader; address 8 holds JMP 10
        ld_req = 1'b1; ld_addr = 8'd3; ld_data = 16'h1000;
        step(1'b0, 1'b0, 0);
        for (int a = 3; a < 256; a++) begin
            d[15:12] = 4'($urandom_range(1, 15));
            d[11:0]  = 12'($urandom);
            if (a == 8) d = 16'h000A;
            ld_addr = 8'(a); ld_data = d;
            step(1'b0, 1'b0, 0);
        end
        ld_req = 1'b0; step(1'b0, 1'b0, 0);

        // Sequential fetch, stall, JMP bubble
        run = 1'b1; instr_ready = 1'b1;
        step(1'b1, 1'b0, 0);                        // IDLE -> FETCH
        step(1'b1, 1'b0, 0);                        // first FETCH cycle
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 2);
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3);
        instr_ready = 1'b1;
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 4);
        step(1'b1, 1'b1, 5);
        step(1'b1, 1'b1, 6);
        step(1'b1, 1'b1, 7);
        step(1'b1, 1'b0, 0);                        // bubble for JMP at 8
        step(1'b1, 1'b1, 10);
        step(1'b1, 1'b1, 11);

        // Redirect while stalled
        instr_ready = 1'b0;
        step(1'b1, 1'b1, 12);
        br_valid = 1'b1; br_target = 8'h1C;
        step(1'b1, 1'b1, 12);
        br_valid = 1'b0; instr_ready = 1'b1;
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 28);
        step(1'b1, 1'b1, 29);

        // pc wrap 255 -> 0
        br_valid = 1'b1; br_target = 8'hFF;
        step(1'b1, 1'b1, 30);
        br_valid = 1'b0;
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 255);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);

        // Stop fetching
        run = 1'b0;
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b0, 0);

        // Reset mid-LOAD: the in-flight write must not land
        saved = mmem[8'h40];
        ld_req = 1'b1; ld_addr = 8'h40; ld_data = ~saved;
        step(1'b0, 1'b0, 0);                        // IDLE -> LOAD
        mid_reset();
        ld_req = 1'b0;
        chk("no_write_on_rst", 32'(mem[8'h40]), 32'(saved));
        step(1'b0, 1'b0, 0);

        // Reset mid-FETCH with a pending stalled word
        run = 1'b1; instr_ready = 1'b0;
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        mid_reset();
        run = 1'b0;
        step(1'b1, 1'b0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            ld_req      = ($urandom_range(0, 3) != 0);
            ld_addr     = 8'($urandom);
            ld_data     = 16'($urandom);
            instr_ready = ($urandom_range(0, 3) != 0);
            br_valid    = ($urandom_range(0, 11) == 0);
            br_target   = 8'($urandom);
            if ($urandom_range(0, 199) == 0) mid_reset();
            else step(1'b0, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
